// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues in-order word fetches, buffers returned
// instructions with their PC, and flushes stale in-flight responses on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_STEP  = 64'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [63:0] req_addr_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_instr_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [63:0] id_pc_o,
  output logic [63:0] id_pcplus_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  typedef enum logic {
    FETCH,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [63:0]   fetch_pc_q;
  logic [63:0]   next_rsp_pc_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [63:0]   pc_mem_q    [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          pop;
  logic          push;
  logic          drop;

  // Buffered entries plus in-flight requests never exceed DEPTH, so a push always has room.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req_valid_o = rst_ni & ~redirect_i & (credit_used < DEPTH_LIM);
  assign req_addr_o  = fetch_pc_q;
  assign req_fire    = req_valid_o & req_ready_i;

  assign id_valid_o  = (count_q != '0);
  assign pop         = id_valid_o & id_ready_i & ~redirect_i;
  assign drop        = rsp_valid_i & (state_q == FLUSH);
  assign push        = rsp_valid_i & (state_q == FETCH) & ~redirect_i;

  assign id_instr_o  = id_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign id_pc_o     = id_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign id_pcplus_o = id_valid_o ? (pc_mem_q[rd_ptr_q] + PC_STEP) : '0;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect_i) begin
      // A response arriving in the redirect cycle is itself stale and is not counted.
      count_d       = '0;
      outstanding_d = outstanding_q - CW'(rsp_valid_i);
      drop_cnt_d    = outstanding_q - CW'(rsp_valid_i);
    end else begin
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_valid_i);
      drop_cnt_d    = drop_cnt_q - CW'(drop);
    end
    state_d = (drop_cnt_d != '0) ? FLUSH : FETCH;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= FETCH;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fetch_pc_q    <= RESET_PC;
      next_rsp_pc_q <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (redirect_i) begin
        fetch_pc_q    <= redirect_pc_i;
        next_rsp_pc_q <= redirect_pc_i;
        rd_ptr_q      <= '0;
        wr_ptr_q      <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + PC_STEP;
        end
        if (push) begin
          next_rsp_pc_q <= next_rsp_pc_q + PC_STEP;
          wr_ptr_q      <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= rsp_instr_i;
      pc_mem_q[wr_ptr_q]    <= next_rsp_pc_q;
    end
  end

  rsp_without_request_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_valid_i |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: queue-based reference model, a modelled
// in-order memory, directed scenarios with literal pins, then a random phase.
module tb_fetch_queue;

  localparam int unsigned DEPTH   = 4;
  localparam logic [63:0] PC_STEP = 64'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_instr = '0;
  logic        id_ready = 1'b0;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [63:0] id_pc_o;
  logic [63:0] id_pcplus_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'd0), .PC_STEP(PC_STEP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready), .req_addr_o(req_addr_o),
    .rsp_valid_i(rsp_valid), .rsp_instr_i(rsp_instr),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pcplus_o(id_pcplus_o)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] addr; } mem_req_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } entry_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int req_pct = 100;
  int id_pct = 100;
  mem_req_t mem_q[$];

  logic [63:0] m_fetch_pc = '0;
  logic [63:0] m_next_pc = '0;
  int          m_out = 0;
  int          m_drop = 0;
  entry_t      m_fifo[$];
  logic [63:0] delivered[$];
  bit          post_reset = 1'b0;

  function automatic logic [31:0] mem_image(input logic [63:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkDelivered(input string name, input int idx, input logic [63:0] exp);
    if (idx < delivered.size()) checkOutput(name, delivered[idx], exp);
    else checkOutput({name, "_count"}, 64'(delivered.size()), 64'(idx + 1));
  endtask

  // One clock of stimulus; the memory answers each accepted request lat cycles later, in order.
  task automatic applyStimulus(input bit rst_val, input bit redir, input logic [63:0] rpc);
    @(negedge clk);
    if (rst_n && req_valid_o && req_ready)
      mem_q.push_back('{due: cyc + lat, addr: req_addr_o});
    @(posedge clk);
    cyc++;
    #1;
    rst_n       = rst_val;
    redirect    = redir;
    redirect_pc = rpc;
    req_ready   = ($urandom_range(99) < req_pct);
    id_ready    = ($urandom_range(99) < id_pct);
    rsp_valid   = 1'b0;
    rsp_instr   = $urandom;
    if (!rst_val) begin
      mem_q.delete();
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_instr = mem_image(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic run(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, '0);
  endtask

  // Compare DUT against the model, then advance the model across the coming edge.
  always @(negedge clk) begin : compare_proc
    logic exp_req_valid;
    logic exp_id_valid;
    logic fire;
    logic pop_now;
    if (!rst_n) begin
      if (post_reset) begin
        checkOutput("rst_req_valid", 64'(req_valid_o), 64'd0);
        checkOutput("rst_id_valid", 64'(id_valid_o), 64'd0);
        checkOutput("rst_id_instr", 64'(id_instr_o), 64'd0);
        checkOutput("rst_id_pc", id_pc_o, 64'd0);
        checkOutput("rst_id_pcplus", id_pcplus_o, 64'd0);
      end
      m_fetch_pc = '0;
      m_next_pc  = '0;
      m_out      = 0;
      m_drop     = 0;
      m_fifo.delete();
      delivered.delete();
      post_reset = 1'b1;
    end else begin
      post_reset    = 1'b0;
      exp_req_valid = (m_fifo.size() + m_out < DEPTH) && !redirect;
      exp_id_valid  = (m_fifo.size() > 0);
      checkOutput("req_valid", 64'(req_valid_o), 64'(exp_req_valid));
      if (exp_req_valid) checkOutput("req_addr", req_addr_o, m_fetch_pc);
      checkOutput("id_valid", 64'(id_valid_o), 64'(exp_id_valid));
      if (exp_id_valid) begin
        checkOutput("id_instr", 64'(id_instr_o), 64'(m_fifo[0].instr));
        checkOutput("id_pc", id_pc_o, m_fifo[0].pc);
        checkOutput("id_pcplus", id_pcplus_o, m_fifo[0].pc + PC_STEP);
      end
      fire    = exp_req_valid && req_ready;
      pop_now = exp_id_valid && id_ready;
      if (redirect) begin
        m_fifo.delete();
        if (rsp_valid) m_out--;
        m_drop     = m_out;
        m_fetch_pc = redirect_pc;
        m_next_pc  = redirect_pc;
      end else begin
        if (pop_now) begin
          delivered.push_back(m_fifo[0].pc);
          void'(m_fifo.pop_front());
        end
        if (rsp_valid) begin
          m_out--;
          if (m_drop > 0) begin
            m_drop--;
          end else begin
            m_fifo.push_back('{instr: mem_image(m_next_pc), pc: m_next_pc});
            m_next_pc = m_next_pc + PC_STEP;
          end
        end
        if (fire) begin
          m_fetch_pc = m_fetch_pc + PC_STEP;
          m_out++;
        end
      end
    end
  end

  initial begin
    // Streaming at latency 1 with decode always ready.
    lat = 1; req_pct = 100; id_pct = 100;
    doReset(3);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s1_req_valid0", 64'(req_valid_o), 64'd1);
    checkOutput("s1_req_addr0", req_addr_o, 64'd0);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s1_req_addr1", req_addr_o, 64'd1);
    checkOutput("s1_id_valid_early", 64'(id_valid_o), 64'd0);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s1_id_valid", 64'(id_valid_o), 64'd1);
    checkOutput("s1_id_pc", id_pc_o, 64'd0);
    checkOutput("s1_id_instr", 64'(id_instr_o), 64'h0000_0000_1234_FFFF);
    run(12);
    checkDelivered("s1_pc0", 0, 64'd0);
    checkDelivered("s1_pc1", 1, 64'd1);
    checkDelivered("s1_pc2", 2, 64'd2);

    // Decode stalled: credits run out after DEPTH requests.
    id_pct = 0;
    doReset(2);
    run(10); #1;
    checkOutput("s2_req_valid_stalled", 64'(req_valid_o), 64'd0);
    checkOutput("s2_head_pc", id_pc_o, 64'd0);
    checkOutput("s2_model_occ", 64'(m_fifo.size()), 64'd4);
    id_pct = 100;
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s2_pop_valid", 64'(id_valid_o), 64'd1);
    checkOutput("s2_resume_addr", req_addr_o, 64'd4);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s2_resume_valid", 64'(req_valid_o), 64'd1);
    checkOutput("s2_resume_addr2", req_addr_o, 64'd4);
    run(10);

    // Redirect with three requests in flight and no response that cycle.
    lat = 4;
    doReset(2);
    run(3);
    applyStimulus(1'b1, 1'b1, 64'h40);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s3_drop", 64'(m_drop), 64'd3);
    checkOutput("s3_id_valid_after", 64'(id_valid_o), 64'd0);
    for (int i = 0; i < 20 && !id_valid_o; i++) begin
      applyStimulus(1'b1, 1'b0, '0); #1;
    end
    checkOutput("s3_first_valid", 64'(id_valid_o), 64'd1);
    checkOutput("s3_first_pc", id_pc_o, 64'h40);
    checkOutput("s3_first_pcplus", id_pcplus_o, 64'h41);
    run(10);
    checkDelivered("s3_pc0", 0, 64'h40);
    checkDelivered("s3_pc1", 1, 64'h41);

    // Redirect coinciding with a response and a pop, two outstanding.
    lat = 2;
    doReset(2);
    run(3);
    applyStimulus(1'b1, 1'b1, 64'h40);
    applyStimulus(1'b1, 1'b0, '0); #1;
    checkOutput("s4_id_valid_after", 64'(id_valid_o), 64'd0);
    checkOutput("s4_drop", 64'(m_drop), 64'd1);
    run(12);
    checkDelivered("s4_pc0", 0, 64'h40);
    checkDelivered("s4_pc1", 1, 64'h41);

    // Sustained push and pop in the same cycle: consecutive PCs, no gaps.
    lat = 1;
    doReset(2);
    run(6);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, '0); #1;
      checkOutput("s5_id_valid", 64'(id_valid_o), 64'd1);
      checkOutput("s5_id_pc", id_pc_o, 64'(4 + i));
      checkOutput("s5_req_addr", req_addr_o, 64'(6 + i));
    end

    // PC wrap after redirect to the top of the address space, then reset mid-stream.
    doReset(2);
    run(2);
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run(12); #1;
    checkDelivered("s6_pc0", 0, 64'hFFFF_FFFF_FFFF_FFFF);
    checkDelivered("s6_pc1", 1, 64'd0);
    checkDelivered("s6_pc2", 2, 64'd1);
    checkOutput("s6_busy_before_reset", 64'(id_valid_o), 64'd1);
    doReset(2); #1;
    checkOutput("s6_rst_req_valid", 64'(req_valid_o), 64'd0);
    checkOutput("s6_rst_req_addr", req_addr_o, 64'd0);
    checkOutput("s6_rst_id_valid", 64'(id_valid_o), 64'd0);
    checkOutput("s6_rst_id_pc", id_pc_o, 64'd0);
    checkOutput("s6_rst_id_pcplus", id_pcplus_o, 64'd0);

    // Random traffic: varying latency, backpressure, redirects and occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      lat     = $urandom_range(4, 1);
      req_pct = $urandom_range(100, 30);
      id_pct  = $urandom_range(100, 20);
      for (int i = 0; i < 100; i++) begin
        int r;
        r = $urandom_range(999);
        if (r < 4) begin
          applyStimulus(1'b0, 1'b0, '0);
        end else if (r < 40) begin
          if ($urandom_range(3) == 0) applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
          else applyStimulus(1'b1, 1'b1, {$urandom, $urandom});
        end else begin
          applyStimulus(1'b1, 1'b0, '0);
        end
      end
    end
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
